// File: rtl/conv_channel_accumulator.sv
// Accumulates per-input-channel float16 partial-sum tiles over `depth` channels, adds a bias,
// applies optional ReLU and presents the finished tile on a valid/ready port.
module conv_channel_accumulator #(
   parameter int unsigned PARA_X      = 3,
   parameter int unsigned PARA_Y      = 3,
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned DEPTH_WIDTH = 10
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                in_valid,
   input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0] in_data,
   input  logic [DEPTH_WIDTH-1:0]              depth,
   input  logic [DATA_WIDTH-1:0]               bias,
   input  logic                                relu_en,
   output logic                                in_ready,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [PARA_X*PARA_Y*DATA_WIDTH-1:0] out_data,
   output logic                                overflow_err
);

   localparam int unsigned N  = PARA_X * PARA_Y;
   localparam int unsigned EW = (N > 1) ? $clog2(N) : 1;
   localparam logic [EW-1:0] LastElem = EW'(N - 1);

   typedef enum logic [1:0] {StIdle, StAcc, StBias, StOut} state_e;

   state_e                  state_q;
   logic [EW-1:0]           elem_q;
   logic [DEPTH_WIDTH-1:0]  chan_q;
   logic [DATA_WIDTH-1:0]   in_reg_q [N];
   logic [DATA_WIDTH-1:0]   acc_q    [N];
   logic [DATA_WIDTH-1:0]   bias_q;
   logic                    relu_q;
   logic [DEPTH_WIDTH-1:0]  depth_m1;
   logic [DATA_WIDTH-1:0]   add_b;
   logic [DATA_WIDTH-1:0]   add_sum;

   // Subnormals flush to zero, Inf/NaN clamp to max finite, RNE, saturating overflow.
   function automatic logic [15:0] fp16_add(input logic [15:0] x, input logic [15:0] y);
      logic              sx, sy, sa, sb;
      logic [4:0]        ex, ey, ea, eb, d;
      logic [10:0]       mx, my, ma, mb;
      logic [27:0]       sh;
      logic [13:0]       ma_ext, mb_sh, m;
      logic [14:0]       sum;
      logic [10:0]       frac;
      logic              rnd;
      logic signed [6:0] exp_r;
      logic [15:0]       res;
      sx = x[15];
      ex = x[14:10];
      mx = {1'b1, x[9:0]};
      sy = y[15];
      ey = y[14:10];
      my = {1'b1, y[9:0]};
      if (ex == 5'd0) begin
         mx = '0;
      end else if (ex == 5'd31) begin
         ex = 5'd30;
         mx = 11'h7FF;
      end
      if (ey == 5'd0) begin
         my = '0;
      end else if (ey == 5'd31) begin
         ey = 5'd30;
         my = 11'h7FF;
      end
      if ({ex, mx} >= {ey, my}) begin
         sa = sx; ea = ex; ma = mx; sb = sy; eb = ey; mb = my;
      end else begin
         sa = sy; ea = ey; ma = my; sb = sx; eb = ex; mb = mx;
      end
      d      = ea - eb;
      sh     = {mb, 17'd0} >> ((d > 5'd27) ? 5'd27 : d);
      mb_sh  = sh[27:14];
      mb_sh[0] = sh[14] | (|sh[13:0]);
      ma_ext = {ma, 3'b000};
      if (sa == sb) sum = {1'b0, ma_ext} + {1'b0, mb_sh};
      else          sum = {1'b0, ma_ext} - {1'b0, mb_sh};
      exp_r = {2'b00, ea};
      if (sum[14]) begin
         m     = sum[14:1];
         m[0]  = sum[1] | sum[0];
         exp_r = exp_r + 7'sd1;
      end else begin
         m = sum[13:0];
         for (int i = 0; i < 13; i++) begin
            if (!m[13]) begin
               m     = m << 1;
               exp_r = exp_r - 7'sd1;
            end
         end
      end
      rnd  = m[2] & (m[1] | m[0] | m[3]);
      frac = {1'b0, m[12:3]} + {10'd0, rnd};
      if (frac[10]) exp_r = exp_r + 7'sd1;
      if (sum == 15'd0)           res = 16'h0000;
      else if (exp_r >= 7'sd31)   res = {sa, 15'h7BFF};
      else if (exp_r <= 7'sd0)    res = 16'h0000;
      else                        res = {sa, exp_r[4:0], frac[9:0]};
      return res;
   endfunction

   always_comb begin
      depth_m1 = (depth == '0) ? '0 : depth - 1'b1;
      add_b    = (state_q == StBias) ? bias_q : in_reg_q[elem_q];
      add_sum  = fp16_add(acc_q[elem_q], add_b);
   end

   always_comb begin
      out_data = '0;
      for (int k = 0; k < int'(N); k++) begin
         out_data[k*DATA_WIDTH +: DATA_WIDTH] = acc_q[k];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         elem_q       <= '0;
         chan_q       <= '0;
         bias_q       <= '0;
         relu_q       <= 1'b0;
         in_ready     <= 1'b1;
         out_valid    <= 1'b0;
         overflow_err <= 1'b0;
         for (int k = 0; k < int'(N); k++) begin
            in_reg_q[k] <= '0;
            acc_q[k]    <= '0;
         end
      end else begin
         if (in_valid && !in_ready) overflow_err <= 1'b1;
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  for (int k = 0; k < int'(N); k++) begin
                     in_reg_q[k] <= in_data[k*DATA_WIDTH +: DATA_WIDTH];
                  end
                  if (chan_q == '0) begin
                     bias_q <= bias;
                     relu_q <= relu_en;
                  end
                  elem_q   <= '0;
                  in_ready <= 1'b0;
                  state_q  <= StAcc;
               end
            end
            StAcc: begin
               // The first channel overwrites so no explicit clear is needed between tiles.
               acc_q[elem_q] <= (chan_q == '0) ? in_reg_q[elem_q] : add_sum;
               if (elem_q == LastElem) begin
                  elem_q <= '0;
                  if (chan_q == depth_m1) begin
                     chan_q  <= '0;
                     state_q <= StBias;
                  end else begin
                     chan_q   <= chan_q + 1'b1;
                     in_ready <= 1'b1;
                     state_q  <= StIdle;
                  end
               end else begin
                  elem_q <= elem_q + 1'b1;
               end
            end
            StBias: begin
               acc_q[elem_q] <= (relu_q && add_sum[15]) ? 16'h0000 : add_sum;
               if (elem_q == LastElem) begin
                  elem_q    <= '0;
                  out_valid <= 1'b1;
                  state_q   <= StOut;
               end else begin
                  elem_q <= elem_q + 1'b1;
               end
            end
            StOut: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_q   <= StIdle;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_channel_accumulator.sv
// Directed bench for conv_channel_accumulator: one task per scenario, inline checks.
module tb_conv_channel_accumulator;

   localparam int N  = 9;
   localparam int TW = N * 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic [TW-1:0] in_data = '0;
   logic [9:0]    depth = 10'd1;
   logic [15:0]   bias = '0;
   logic          relu_en = 1'b0;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [TW-1:0] out_data;
   logic          overflow_err;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   conv_channel_accumulator #(
      .PARA_X(3), .PARA_Y(3), .DATA_WIDTH(16), .DEPTH_WIDTH(10)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .depth(depth),
      .bias(bias), .relu_en(relu_en), .in_ready(in_ready), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .overflow_err(overflow_err)
   );

   function automatic logic [TW-1:0] rep(input logic [15:0] v);
      logic [TW-1:0] t;
      for (int k = 0; k < N; k++) t[k*16 +: 16] = v;
      return t;
   endfunction

   function automatic logic [TW-1:0] pack(input logic [15:0] v [9]);
      logic [TW-1:0] t;
      for (int k = 0; k < N; k++) t[k*16 +: 16] = v[k];
      return t;
   endfunction

   task automatic send_tile(input logic [TW-1:0] d);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #12;
      checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready);
      else passed++;
      checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid);
      else passed++;
      checks++; if (out_data !== '0) $display("FAIL reset_out_data got %h exp 0", out_data);
      else passed++;
      checks++; if (overflow_err !== 1'b0) $display("FAIL reset_ovf got %b exp 0", overflow_err);
      else passed++;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic_latency();
      depth = 10'd1; bias = 16'h3C00; relu_en = 1'b0;
      send_tile(rep(16'h3C00));
      checks++; if (in_ready !== 1'b0) $display("FAIL busy_in_ready got %b exp 0", in_ready);
      else passed++;
      repeat (17) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) $display("FAIL latency_early got %b exp 0", out_valid);
      else passed++;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) $display("FAIL latency_19 got %b exp 1", out_valid);
      else passed++;
      checks++; if (out_data !== rep(16'h4000))
         $display("FAIL basic_data got %h exp %h", out_data, rep(16'h4000));
      else passed++;
      drain();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL handshake got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
      else passed++;
   endtask

   task automatic test_multi_channel();
      bit seen;
      depth = 10'd3; bias = 16'h0000; relu_en = 1'b0;
      send_tile(rep(16'h3C00));
      repeat (10) @(posedge clk);
      send_tile(rep(16'h4000));
      repeat (10) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) $display("FAIL multi_early got %b exp 0", out_valid);
      else passed++;
      send_tile(rep(16'h3800));
      wait_out(seen);
      checks++; if (seen !== 1'b1) $display("FAIL multi_timeout got %b exp 1", seen);
      else passed++;
      checks++; if (out_data !== rep(16'h4300))
         $display("FAIL multi_data got %h exp %h", out_data, rep(16'h4300));
      else passed++;
      drain();
      repeat (25) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) $display("FAIL multi_single got %b exp 0", out_valid);
      else passed++;
   endtask

   task automatic test_relu();
      bit seen;
      depth = 10'd1; bias = 16'h3800; relu_en = 1'b1;
      send_tile(rep(16'hC000));
      wait_out(seen);
      checks++; if (!seen || out_data !== rep(16'h0000))
         $display("FAIL relu_on got %h exp %h", out_data, rep(16'h0000));
      else passed++;
      drain();
      relu_en = 1'b0;
      send_tile(rep(16'hC000));
      wait_out(seen);
      checks++; if (!seen || out_data !== rep(16'hBE00))
         $display("FAIL relu_off got %h exp %h", out_data, rep(16'hBE00));
      else passed++;
      drain();
   endtask

   task automatic test_backpressure_overflow();
      bit seen;
      bit stable;
      depth = 10'd1; bias = 16'h0000; relu_en = 1'b0;
      send_tile(rep(16'h3C00));
      wait_out(seen);
      stable = seen;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_data !== rep(16'h3C00) || out_valid !== 1'b1) stable = 1'b0;
      end
      checks++; if (stable !== 1'b1) $display("FAIL hold_stable got %b exp 1", stable);
      else passed++;
      send_tile(rep(16'h5555));
      checks++; if (overflow_err !== 1'b1) $display("FAIL ovf_set got %b exp 1", overflow_err);
      else passed++;
      checks++; if (out_data !== rep(16'h3C00))
         $display("FAIL ovf_drop got %h exp %h", out_data, rep(16'h3C00));
      else passed++;
      drain();
      bias = 16'h3C00;
      send_tile(rep(16'h4000));
      wait_out(seen);
      checks++; if (!seen || out_data !== rep(16'h4200))
         $display("FAIL after_ovf got %h exp %h", out_data, rep(16'h4200));
      else passed++;
      checks++; if (overflow_err !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", overflow_err);
      else passed++;
      drain();
   endtask

   task automatic test_arith_edges();
      bit seen;
      logic [15:0] a [9];
      logic [15:0] b [9];
      logic [15:0] r [9];
      a = '{16'h3C00, 16'h3C01, 16'h3C00, 16'h4000, 16'h3C00,
            16'h7BFF, 16'h7BFF, 16'h7BFF, 16'h7BFF};
      b = '{16'h1000, 16'h1000, 16'h1400, 16'hBC00, 16'hBC00,
            16'h7BFF, 16'h7BFF, 16'h7BFF, 16'h7BFF};
      r = '{16'h3C00, 16'h3C02, 16'h3C01, 16'h3C00, 16'h0000,
            16'h7BFF, 16'h7BFF, 16'h7BFF, 16'h7BFF};
      depth = 10'd2; bias = 16'h0000; relu_en = 1'b0;
      send_tile(pack(a));
      repeat (10) @(posedge clk);
      send_tile(pack(b));
      wait_out(seen);
      checks++; if (!seen || out_data !== pack(r))
         $display("FAIL round_sat got %h exp %h", out_data, pack(r));
      else passed++;
      drain();
      // depth 0 acts as a single channel; flush, -0, Inf clamp and passthrough per element
      a = '{16'h0001, 16'h8000, 16'h3C00, 16'hBC00, 16'h7C00,
            16'hFC00, 16'h3555, 16'h0400, 16'h4000};
      r = '{16'h0000, 16'h0000, 16'h3C00, 16'hBC00, 16'h7BFF,
            16'hFBFF, 16'h3555, 16'h0400, 16'h4000};
      depth = 10'd0;
      send_tile(pack(a));
      wait_out(seen);
      checks++; if (!seen || out_data !== pack(r))
         $display("FAIL flush_depth0 got %h exp %h", out_data, pack(r));
      else passed++;
      drain();
   endtask

   task automatic test_reset_mid_acc();
      bit seen;
      depth = 10'd1; bias = 16'h3C00; relu_en = 1'b0;
      send_tile(rep(16'h3C00));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #2;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || overflow_err !== 1'b0)
         $display("FAIL midreset_ctrl got r=%b v=%b o=%b exp r=1 v=0 o=0",
                  in_ready, out_valid, overflow_err);
      else passed++;
      checks++; if (out_data !== '0) $display("FAIL midreset_data got %h exp 0", out_data);
      else passed++;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      send_tile(rep(16'h4000));
      wait_out(seen);
      checks++; if (!seen || out_data !== rep(16'h4200))
         $display("FAIL post_reset got %h exp %h", out_data, rep(16'h4200));
      else passed++;
      drain();
   endtask

   initial begin
      test_reset();
      test_basic_latency();
      test_multi_channel();
      test_relu();
      test_backpressure_overflow();
      test_arith_edges();
      test_reset_mid_acc();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
